// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: pipeline write-back, long-latency unit handshake and regfile write port.
// master = wb stage / LU / ctrl side, slave = arbiter side.
interface wb_port_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic [AW-1:0] pipe_wd;
    logic          pipe_wreg;
    logic [DW-1:0] pipe_wdata;

    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_wd;
    logic [DW-1:0] lu_wdata;

    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    logic          stall_req;

    modport master (
        output pipe_wd, pipe_wreg, pipe_wdata,
        output lu_valid, lu_wd, lu_wdata,
        input  lu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  stall_req
    );

    modport slave (
        input  pipe_wd, pipe_wreg, pipe_wdata,
        input  lu_valid, lu_wd, lu_wdata,
        output lu_ready,
        output rf_we, rf_waddr, rf_wdata,
        output stall_req
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline write-back has priority, LU result waits in a 1-entry buffer.
// Optional WB_ARB_STATS_EN adds stat_lu_wr / stat_stall event counters.
module wb_port_arbiter #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    wb_port_arbiter_if.slave bus
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]      stat_lu_wr,
    output logic [31:0]      stat_stall
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FORCE = 2'd2;

    localparam int            CW      = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] buf_wd;
    logic [DW-1:0] buf_wdata;

    logic buf_full;
    logic lu_xfer;
    logic squash;
    logic zero_drop;
    logic lu_grant;
    logic buf_clear;
    logic blocked;

    // The buffer holds an entry exactly while the FSM is out of IDLE.
    assign buf_full     = (state != ST_IDLE);
    assign bus.lu_ready = !buf_full && !rst;
    assign lu_xfer      = bus.lu_valid && bus.lu_ready;

    // A younger pipeline write to the same register makes the buffered value dead.
    assign squash    = bus.pipe_wreg && buf_full && (bus.pipe_wd == buf_wd);
    // $0 results never need the port, so they leave the buffer at the first edge.
    assign zero_drop = buf_full && (buf_wd == '0);
    assign lu_grant  = !bus.pipe_wreg && buf_full && (buf_wd != '0);
    assign buf_clear = squash || zero_drop || lu_grant;
    assign blocked   = bus.pipe_wreg && buf_full && !squash && !zero_drop;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (lu_xfer) begin
                    state_nxt = ST_PEND;
                    cnt_nxt   = '0;
                end
            end
            ST_PEND, ST_FORCE: begin
                if (buf_clear) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (blocked) begin
                    if (cnt != CNT_MAX)
                        cnt_nxt = cnt + CW'(1);
                    if (cnt_nxt == CNT_MAX)
                        state_nxt = ST_FORCE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bus.stall_req <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            bus.stall_req <= (state_nxt == ST_FORCE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else if (bus.pipe_wreg) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= bus.pipe_wd;
            bus.rf_wdata <= bus.pipe_wdata;
        end else if (lu_grant) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= buf_wd;
            bus.rf_wdata <= buf_wdata;
        end else begin
            bus.rf_we    <= 1'b0;
        end
    end

    // NOTE: buffer payload has no reset; it is only ever read while buf_full, which is reset.
    always_ff @(posedge clk) begin
        if (lu_xfer) begin
            buf_wd    <= bus.lu_wd;
            buf_wdata <= bus.lu_wdata;
        end
    end

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lu_wr <= '0;
            stat_stall <= '0;
        end else begin
            if (lu_grant)
                stat_lu_wr <= stat_lu_wr + 32'd1;
            if (bus.stall_req)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand sequences for starvation/reset,
// then random traffic against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    wb_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    wb_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pw;
        logic [4:0]  pwd;
        logic [31:0] pwdata;
        logic        lv;
        logic [4:0]  lwd;
        logic [31:0] lwdata;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        stall;
        logic        ready;
    } vec_t;

    typedef struct {
        logic [4:0]  wd;
        logic [31:0] wdata;
    } ent_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pwd, input logic [31:0] pwdata,
                         input logic lv, input logic [4:0] lwd, input logic [31:0] lwdata);
        bus.pipe_wreg  = pw;
        bus.pipe_wd    = pwd;
        bus.pipe_wdata = pwdata;
        bus.lu_valid   = lv;
        bus.lu_wd      = lwd;
        bus.lu_wdata   = lwdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic we, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic stall, input logic ready);
        check({tag, ".rf_we"},     32'(bus.rf_we),     32'(we));
        check({tag, ".rf_waddr"},  32'(bus.rf_waddr),  32'(waddr));
        check({tag, ".rf_wdata"},  bus.rf_wdata,       wdata);
        check({tag, ".stall_req"}, 32'(bus.stall_req), 32'(stall));
        check({tag, ".lu_ready"},  32'(bus.lu_ready),  32'(ready));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ent_t        q[$];
        int          starve;
        logic [4:0]  m_addr;
        logic [31:0] m_data;
        logic        m_we;

        // Rows apply in order from reset; expected outputs are sampled after the following edge.
        vecs[0]  = '{1'b1, 5'd3,  32'h1234, 1'b0, 5'd0,  32'h0,    1'b1, 5'd3,  32'h1234, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd3,  32'h1234, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'hCAFE, 1'b0, 5'd3,  32'h1234, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'hCAFE, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd9,  32'hBEEF, 1'b0, 5'd7,  32'hCAFE, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd9,  32'h1,    1'b0, 5'd0,  32'h0,    1'b1, 5'd9,  32'h1,    1'b0, 1'b1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd9,  32'h1,    1'b0, 1'b1};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'hDEAD, 1'b0, 5'd9,  32'h1,    1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd9,  32'h1,    1'b0, 1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd9,  32'h1,    1'b0, 1'b1};
        vecs[10] = '{1'b1, 5'd2,  32'h22,   1'b1, 5'd4,  32'h44,   1'b1, 5'd2,  32'h22,   1'b0, 1'b0};
        vecs[11] = '{1'b1, 5'd6,  32'h66,   1'b1, 5'd8,  32'h88,   1'b1, 5'd6,  32'h66,   1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd4,  32'h44,   1'b0, 1'b1};
        vecs[13] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd11, 32'hAB,   1'b0, 5'd4,  32'h44,   1'b0, 1'b0};
        vecs[14] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd12, 32'hCD,   1'b1, 5'd11, 32'hAB,   1'b0, 1'b1};
        vecs[15] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd12, 32'hCD,   1'b0, 5'd11, 32'hAB,   1'b0, 1'b0};
        vecs[16] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd12, 32'hCD,   1'b0, 1'b1};

        // Reset values while rst is held, then lu_ready after release.
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check_outs("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("release.lu_ready", 32'(bus.lu_ready), 32'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].pw, vecs[i].pwd, vecs[i].pwdata, vecs[i].lv, vecs[i].lwd, vecs[i].lwdata);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                       vecs[i].stall, vecs[i].ready);
        end

        // Starvation: four blocked cycles raise stall_req; a pipe write during FORCE still wins.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h55);
        step();
        check_outs("starve.load", 1'b0, 5'd12, 32'hCD, 1'b0, 1'b0);
        for (int k = 0; k < SM; k++) begin
            drive(1'b1, 5'(k + 1), 32'h100 + 32'(k), 1'b0, 5'd0, 32'h0);
            step();
            check_outs($sformatf("starve.blk%0d", k), 1'b1, 5'(k + 1), 32'h100 + 32'(k),
                       (k == SM - 1), 1'b0);
        end
        drive(1'b1, 5'd20, 32'hF0, 1'b0, 5'd0, 32'h0);
        step();
        check_outs("starve.force_pipe", 1'b1, 5'd20, 32'hF0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        check_outs("starve.drain", 1'b1, 5'd5, 32'h55, 1'b0, 1'b1);

        // Async reset while in FORCE: outputs clear without a clock edge; the entry is lost.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h77);
        step();
        for (int k = 0; k < SM; k++) begin
            drive(1'b1, 5'd1, 32'h9, 1'b0, 5'd0, 32'h0);
            step();
        end
        check("rstseq.stall_before", 32'(bus.stall_req), 32'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check_outs("rstseq.async", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        step();
        check_outs("rstseq.held", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("rstseq.ready_after", 32'(bus.lu_ready), 32'd1);
        step();
        check_outs("rstseq.discarded", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // Random traffic against the reference model (buffer as a queue, starvation as a count).
        starve = 0;
        m_addr = '0;
        m_data = '0;
        for (int i = 0; i < 3000; i++) begin
            logic        pw, lv, xfer;
            logic [4:0]  pwd, lwd;
            logic [31:0] pwdata, lwdata;
            int          pct;
            pct    = (i % 400 < 200) ? 85 : 40;
            pw     = ($urandom_range(99) < pct);
            pwd    = 5'($urandom_range(15));
            pwdata = $urandom;
            lv     = 1'($urandom_range(1));
            lwd    = 5'($urandom_range(15));
            lwdata = $urandom;
            drive(pw, pwd, pwdata, lv, lwd, lwdata);
            #1;
            check("rand.lu_ready_pre", 32'(bus.lu_ready), 32'(q.size() == 0));

            xfer = lv && (q.size() == 0);
            m_we = 1'b0;
            if (pw) begin
                m_we   = 1'b1;
                m_addr = pwd;
                m_data = pwdata;
                if (q.size() != 0) begin
                    if (q[0].wd == pwd || q[0].wd == 5'd0) begin
                        void'(q.pop_front());
                        starve = 0;
                    end else if (starve < SM) begin
                        starve++;
                    end
                end
            end else if (q.size() != 0) begin
                if (q[0].wd != 5'd0) begin
                    m_we   = 1'b1;
                    m_addr = q[0].wd;
                    m_data = q[0].wdata;
                end
                void'(q.pop_front());
                starve = 0;
            end
            if (xfer) begin
                q.push_back('{wd: lwd, wdata: lwdata});
                starve = 0;
            end

            step();
            check_outs($sformatf("rand%0d", i), m_we, m_addr, m_data,
                       (q.size() != 0) && (starve >= SM), (q.size() == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
